// File: rtl/vga_timing_gen_if.sv
// Signal bundle between the VGA raster engine, its pixel source and the board DAC.
// The pattern_en line exists only when VGA_TEST_PATTERN_EN is defined.
interface vga_timing_gen_if #(
   parameter int COLOR_W = 4,
   parameter int CNT_W   = 10
);
   logic [COLOR_W-1:0] red_in;
   logic [COLOR_W-1:0] green_in;
   logic [COLOR_W-1:0] blue_in;
`ifdef VGA_TEST_PATTERN_EN
   logic               pattern_en;
`endif
   logic [CNT_W-1:0]   DrawX;
   logic [CNT_W-1:0]   DrawY;
   logic               draw_en;
   logic               frame_start;
   logic [COLOR_W-1:0] VGA_R;
   logic [COLOR_W-1:0] VGA_G;
   logic [COLOR_W-1:0] VGA_B;
   logic               VGA_HS;
   logic               VGA_VS;

   // master is the timing engine; slave is the pixel source plus DAC side
   modport master (
`ifdef VGA_TEST_PATTERN_EN
      input  pattern_en,
`endif
      input  red_in, green_in, blue_in,
      output DrawX, DrawY, draw_en, frame_start,
      output VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS
   );

   modport slave (
`ifdef VGA_TEST_PATTERN_EN
      output pattern_en,
`endif
      output red_in, green_in, blue_in,
      input  DrawX, DrawY, draw_en, frame_start,
      input  VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS
   );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster engine: pixel strobe, h/v counters, registered RGB/HS/VS.
// Define VGA_TEST_PATTERN_EN to add the pattern_en port and an eight-bar colour generator.
module vga_timing_gen #(
   parameter int COLOR_W  = 4,
   parameter int CLK_DIV  = 2,
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int SYNC_POL = 0,
   parameter int CNT_W    = 10
) (
   input  logic             Clk,
   input  logic             Reset,
   vga_timing_gen_if.master vga
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int H_SYNC_BEG = H_ACTIVE + H_FP;
   localparam int H_SYNC_END = H_ACTIVE + H_FP + H_SYNC;
   localparam int V_SYNC_BEG = V_ACTIVE + V_FP;
   localparam int V_SYNC_END = V_ACTIVE + V_FP + V_SYNC;
   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
   localparam logic             SYNC_ON  = (SYNC_POL != 0);

   function automatic logic [COLOR_W-1:0] blank_gate(input logic                en,
                                                     input logic [COLOR_W-1:0] c);
      return en ? c : '0;
   endfunction

   function automatic logic sync_level(input logic act);
      return act ? SYNC_ON : ~SYNC_ON;
   endfunction

`ifdef VGA_TEST_PATTERN_EN
   function automatic logic [2:0] bar_index(input logic [CNT_W-1:0] x);
      logic [CNT_W+2:0] scaled;
      logic [CNT_W+2:0] idx;
      scaled = {x, 3'b000};
      idx    = scaled / (CNT_W+3)'(H_ACTIVE);
      return idx[2:0];
   endfunction

   function automatic logic [COLOR_W-1:0] bar_level(input logic on);
      return on ? {COLOR_W{1'b1}} : '0;
   endfunction
`endif

   // ---- stage p0: pixel strobe and raster counters ----
   logic [DIV_W-1:0] div_p0;
   logic [CNT_W-1:0] h_p0;
   logic [CNT_W-1:0] v_p0;
   logic             pix_tick;
   logic             h_wrap;
   logic             v_wrap;

   // with CLK_DIV = 1 the last count is 0, so div stays 0 and every cycle ticks
   assign pix_tick = (div_p0 == DIV_LAST);
   assign h_wrap   = (h_p0 == H_LAST);
   assign v_wrap   = (v_p0 == V_LAST);

   always_ff @(posedge Clk) begin
      if (Reset) begin
         div_p0 <= '0;
      end else if (pix_tick) begin
         div_p0 <= '0;
      end else begin
         div_p0 <= div_p0 + DIV_W'(1);
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         h_p0 <= '0;
         v_p0 <= '0;
      end else if (pix_tick) begin
         if (h_wrap) begin
            h_p0 <= '0;
            v_p0 <= v_wrap ? '0 : v_p0 + CNT_W'(1);
         end else begin
            h_p0 <= h_p0 + CNT_W'(1);
         end
      end
   end

   logic draw_en_p0;
   logic hs_act_p0;
   logic vs_act_p0;
   logic frame_start_p0;

   assign draw_en_p0 = (int'(h_p0) < H_ACTIVE) && (int'(v_p0) < V_ACTIVE);
   assign hs_act_p0  = (int'(h_p0) >= H_SYNC_BEG) && (int'(h_p0) < H_SYNC_END);
   assign vs_act_p0  = (int'(v_p0) >= V_SYNC_BEG) && (int'(v_p0) < V_SYNC_END);
   // a reset landing on the wrap edge aborts the frame, so it must not pulse
   assign frame_start_p0 = pix_tick && h_wrap && v_wrap && !Reset;

   logic [COLOR_W-1:0] src_r_p0;
   logic [COLOR_W-1:0] src_g_p0;
   logic [COLOR_W-1:0] src_b_p0;

`ifdef VGA_TEST_PATTERN_EN
   logic [2:0] bar_p0;
   assign bar_p0 = bar_index(h_p0);

   always_comb begin
      src_r_p0 = vga.red_in;
      src_g_p0 = vga.green_in;
      src_b_p0 = vga.blue_in;
      if (vga.pattern_en) begin
         src_r_p0 = bar_level(bar_p0[2]);
         src_g_p0 = bar_level(bar_p0[1]);
         src_b_p0 = bar_level(bar_p0[0]);
      end
   end
`else
   always_comb begin
      src_r_p0 = vga.red_in;
      src_g_p0 = vga.green_in;
      src_b_p0 = vga.blue_in;
   end
`endif

   // ---- stage p1: DAC-facing registers, one pixel period behind the counters ----
   logic [COLOR_W-1:0] r_p1;
   logic [COLOR_W-1:0] g_p1;
   logic [COLOR_W-1:0] b_p1;
   logic               hs_p1;
   logic               vs_p1;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_p1  <= '0;
         g_p1  <= '0;
         b_p1  <= '0;
         hs_p1 <= ~SYNC_ON;
         vs_p1 <= ~SYNC_ON;
      end else if (pix_tick) begin
         r_p1  <= blank_gate(draw_en_p0, src_r_p0);
         g_p1  <= blank_gate(draw_en_p0, src_g_p0);
         b_p1  <= blank_gate(draw_en_p0, src_b_p0);
         hs_p1 <= sync_level(hs_act_p0);
         vs_p1 <= sync_level(vs_act_p0);
      end
   end

   assign vga.DrawX       = h_p0;
   assign vga.DrawY       = v_p0;
   assign vga.draw_en     = draw_en_p0;
   assign vga.frame_start = frame_start_p0;
   assign vga.VGA_R       = r_p1;
   assign vga.VGA_G       = g_p1;
   assign vga.VGA_B       = b_p1;
   assign vga.VGA_HS      = hs_p1;
   assign vga.VGA_VS      = vs_p1;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomised bench for vga_timing_gen on a 14x7 raster, checked against a
// position-from-elapsed-time reference model.
module tb_vga_timing_gen;

   localparam int CW    = 4;
   localparam int NW    = 4;
   localparam int DIV   = 2;
   localparam int H_ACT = 8;
   localparam int HT    = 14;
   localparam int V_ACT = 4;
   localparam int VT    = 7;

   logic Clk = 1'b0;
   logic Reset;

   vga_timing_gen_if #(.COLOR_W(CW), .CNT_W(NW)) vga ();

   vga_timing_gen #(
      .COLOR_W(CW), .CLK_DIV(DIV),
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .SYNC_POL(0), .CNT_W(NW)
   ) dut (
      .Clk   (Clk),
      .Reset (Reset),
      .vga   (vga)
   );

   always #5 Clk = ~Clk;

   int n_vec;
   int n_err;
   int t;          // active clock edges since reset was last released
   int cyc;
   int last_fs;
   bit have_fs;
   bit rst_since;
   int cmode;
   logic pe;
   logic [CW-1:0] exp_r, exp_g, exp_b;
   logic exp_hs, exp_vs;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic int pos_h(input int tt);
      return (tt / DIV) % HT;
   endfunction

   function automatic int pos_v(input int tt);
      return ((tt / DIV) / HT) % VT;
   endfunction

   task automatic cycle(input logic rst_v);
      int h, v, bar;
      logic tick, de;
      logic [CW-1:0] r, g, b, sr, sg, sb;
      @(negedge Clk);
      Reset = rst_v;
      if (cmode == 0) begin
         r = vga.DrawX[3:0];
         g = 4'hA;
         b = 4'h5;
      end else begin
         r = 4'($urandom_range(0, 15));
         g = 4'($urandom_range(0, 15));
         b = 4'($urandom_range(0, 15));
      end
`ifdef VGA_TEST_PATTERN_EN
      if (cmode == 2) pe = 1'b1;
      else if (cmode == 1) pe = 1'($urandom_range(0, 1));
      else pe = 1'b0;
      vga.pattern_en = pe;
`endif
      vga.red_in   = r;
      vga.green_in = g;
      vga.blue_in  = b;
      #1;
      h    = pos_h(t);
      v    = pos_v(t);
      tick = ((t % DIV) == DIV - 1);
      de   = (h < H_ACT) && (v < V_ACT);
      check("drawx",       32'(vga.DrawX),       32'(h));
      check("drawy",       32'(vga.DrawY),       32'(v));
      check("draw_en",     32'(vga.draw_en),     32'(de));
      check("frame_start", 32'(vga.frame_start), 32'(tick && h == HT-1 && v == VT-1 && !rst_v));
      check("vga_r",       32'(vga.VGA_R),       32'(exp_r));
      check("vga_g",       32'(vga.VGA_G),       32'(exp_g));
      check("vga_b",       32'(vga.VGA_B),       32'(exp_b));
      check("vga_hs",      32'(vga.VGA_HS),      32'(exp_hs));
      check("vga_vs",      32'(vga.VGA_VS),      32'(exp_vs));
      if (vga.frame_start === 1'b1) begin
         if (have_fs && !rst_since) check("fs_period", 32'(cyc - last_fs), 32'(HT*VT*DIV));
         have_fs   = 1'b1;
         last_fs   = cyc;
         rst_since = 1'b0;
      end
      if (rst_v) begin
         t = 0;
         exp_r = '0; exp_g = '0; exp_b = '0;
         exp_hs = 1'b1; exp_vs = 1'b1;
         rst_since = 1'b1;
      end else begin
         if (tick) begin
            sr = r; sg = g; sb = b;
            if (pe) begin
               bar = (h * 8) / H_ACT;
               sr = ((bar & 4) != 0) ? 4'hF : 4'h0;
               sg = ((bar & 2) != 0) ? 4'hF : 4'h0;
               sb = ((bar & 1) != 0) ? 4'hF : 4'h0;
            end
            exp_r  = de ? sr : 4'h0;
            exp_g  = de ? sg : 4'h0;
            exp_b  = de ? sb : 4'h0;
            exp_hs = !(h >= 10 && h < 12);
            exp_vs = !(v == 5);
         end
         t++;
      end
      cyc++;
   endtask

   initial begin
      bit found;
      n_vec = 0; n_err = 0; t = 0; cyc = 0;
      have_fs = 1'b0; rst_since = 1'b1; last_fs = 0;
      cmode = 0; pe = 1'b0;
      exp_r = '0; exp_g = '0; exp_b = '0; exp_hs = 1'b1; exp_vs = 1'b1;
      Reset = 1'b1;
      vga.red_in = '0; vga.green_in = '0; vga.blue_in = '0;
`ifdef VGA_TEST_PATTERN_EN
      vga.pattern_en = 1'b0;
`endif
      repeat (3) @(posedge Clk);

      // two-plus frames free-running with the DrawX-driven colour source
      repeat (450) cycle(1'b0);

      // abort the frame at (6,2) on a pixel edge
      found = 1'b0;
      for (int k = 0; k < 400 && !found; k++) begin
         if (pos_h(t) == 6 && pos_v(t) == 2 && (t % DIV) == DIV - 1) begin
            cycle(1'b1);
            found = 1'b1;
         end else begin
            cycle(1'b0);
         end
      end
      check("abort_reached", 32'(found), 32'd1);
      repeat (250) cycle(1'b0);

      // random colours, random pattern select, sparse random resets
      cmode = 1;
      repeat (1200) cycle(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);

`ifdef VGA_TEST_PATTERN_EN
      cmode = 2;
      repeat (200) cycle(1'b0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster engine that replaces the fixed 640x480, 4-bit-per-channel VGA path of the lab SoC. It derives a pixel strobe from the system clock, runs horizontal and vertical counters, and publishes the current draw coordinate to the pixel source. It registers that source's colour into aligned RGB, HS and VS outputs for the board DAC. Frame geometry, sync polarity, clock division and colour depth are all parameters; an optional built-in colour-bar generator serves bring-up.

## Interface
- COLOR_W, 4: bits per colour channel.
- CLK_DIV, 2: system clocks per pixel; must be ≥1 (2 gives 25 MHz from 50 MHz).
- H_ACTIVE / H_FP / H_SYNC / H_BP, 640 / 16 / 96 / 48: horizontal segment lengths, in pixels.
- V_ACTIVE / V_FP / V_SYNC / V_BP, 480 / 10 / 2 / 33: vertical segment lengths, in lines.
- SYNC_POL, 0: asserted sync level (0 means active-low).
- CNT_W, 10: coordinate width; 2^CNT_W must be ≥ H_TOTAL and ≥ V_TOTAL.
- Clk  in  1  single system clock; every register uses its rising edge.
- Reset  in  1  synchronous, active-high reset.
- red_in / green_in / blue_in  in  COLOR_W  pixel colour for the current DrawX/DrawY.
- DrawX / DrawY  out  CNT_W  current horizontal and vertical counter values.
- draw_en  out  1  high when the current coordinate lies in the active region.
- frame_start  out  1  one-Clk pulse when the counters wrap to (0,0).
- VGA_R / VGA_G / VGA_B  out  COLOR_W  registered colour, zero during blanking.
- VGA_HS / VGA_VS  out  1  registered sync outputs.
- pattern_en  in  1  selects the test pattern; present only with VGA_TEST_PATTERN_EN.

## Operation
- H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP; V_TOTAL is formed the same way.
- Divider:
  - div counts 0..CLK_DIV-1 and wraps.
  - pix_tick = (div == CLK_DIV-1).
  - CLK_DIV = 1 gives pix_tick on every cycle.
- Counters advance only on pix_tick:
  - h = h+1; at h = H_TOTAL-1, h wraps to 0 and v increments.
  - At v = V_TOTAL-1 with h wrapping, v wraps to 0.
- DrawX = h and DrawY = v, taken directly from the counter registers.
- draw_en = (h < H_ACTIVE) && (v < V_ACTIVE), combinational from the counters.
- hs_act = (H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC); vs_act is defined the same way on v.
- Output stage, updated on pix_tick only:
  - VGA_R/G/B ← draw_en ? colour source : 0.
  - VGA_HS ← hs_act ? SYNC_POL : ~SYNC_POL; VGA_VS is formed the same way from vs_act.
- Colour source is red_in/green_in/blue_in, sampled in the same Clk cycle as pix_tick.
- frame_start is high for exactly one Clk cycle, in the pix_tick cycle where h = H_TOTAL-1 and v = V_TOTAL-1 (the wrap edge).
- Reset values:
  - div, h and v = 0.
  - VGA_R/G/B = 0.
  - VGA_HS = VGA_VS = ~SYNC_POL (inactive).
  - frame_start = 0.
  - DrawX = DrawY = 0; draw_en = 1.
- Reset asserted mid-frame: all state returns to the reset values on the next edge, and the raster restarts at (0,0). No frame_start pulse is produced for the aborted frame.

## Timing
- Output latency: VGA_* reflect counter position (h,v) one pixel period after DrawX/DrawY present it. HS, VS and colour stay mutually aligned.
- The pixel source must drive valid colour within the pixel period. Colour is sampled only on the pix_tick cycle, and any value outside that cycle is ignored.
- First pix_tick after reset release occurs CLK_DIV cycles later. That edge loads the outputs for pixel (0,0) and advances h to 1.
- Default frame length: 800 × 525 × CLK_DIV = 840,000 Clk cycles.

## Configuration
- VGA_TEST_PATTERN_EN defined:
  - Adds the pattern_en port.
  - When pattern_en = 1, the colour source is eight vertical bars; bar index i = (h×8)/H_ACTIVE, 3 bits.
  - Bar colours: R = all-ones if i[2], G = all-ones if i[1], B = all-ones if i[0]; otherwise 0.
  - red_in/green_in/blue_in are ignored while pattern_en = 1.
- VGA_TEST_PATTERN_EN undefined:
  - No pattern_en port and no pattern logic.
  - Colour always comes from red_in/green_in/blue_in.

## Test plan
Bench parameters: H = 8/2/2/2 (H_TOTAL 14), V = 4/1/1/1 (V_TOTAL 7), CLK_DIV = 2, COLOR_W = 4.
- Reset held 3 cycles, then released → all outputs at reset values; first pix_tick in cycle 2 after release; DrawX steps 0..13 every 2 cycles.
- Free run for 2 frames → frame_start pulses exactly every 196 Clk cycles, each pulse 1 cycle wide.
- Sync windows → VGA_HS is low for pixel positions 10–11 (2 pixels = 4 Clk per line); VGA_VS is low for the whole of line 5.
- Drive red_in = DrawX[3:0], green_in = 0xA, blue_in = 0x5 → VGA_R equals the previous-pixel DrawX during active pixels; all colour outputs read 0 for h ≥ 8 or v ≥ 4.
- Assert Reset at h=6, v=2 for 1 cycle → next cycle h = v = 0, HS/VS inactive, no spurious frame_start pulse.
- With VGA_TEST_PATTERN_EN and pattern_en = 1 → pixel 7 outputs R=G=B=0xF; pixel 0 outputs 0/0/0; pixel 4 outputs R=0xF, G=0, B=0.
